// File: rtl/nios2_debug_cmd_bridge_if.sv
// nios2_debug_cmd_bridge_if: scan-chain strobes, channel handshakes and decoded command outputs of the bridge.
interface nios2_debug_cmd_bridge_if #(
   parameter int IR_W = 2,
   parameter int DR_W = 38,
   parameter int NUM_CH = 4
);
   logic vs_udr, vs_uir, err_clr;
   logic [IR_W-1:0] ir_in, ir_latched;
   logic [DR_W-1:0] sr, jdo;
   logic [NUM_CH-1:0] ch_ready, take_action, take_no_action;
   logic busy, overrun, invalid_ir;
   logic [15:0] cmd_count;
   modport master (
      output vs_udr, vs_uir, ir_in, sr, ch_ready, err_clr,
      input jdo, ir_latched, take_action, take_no_action, busy, overrun, invalid_ir, cmd_count
   );
   modport slave (
      input vs_udr, vs_uir, ir_in, sr, ch_ready, err_clr,
      output jdo, ir_latched, take_action, take_no_action, busy, overrun, invalid_ir, cmd_count
   );
endinterface

// File: rtl/nios2_debug_cmd_bridge.sv
// nios2_debug_cmd_bridge: synchronises virtual-JTAG update strobes into clk and dispatches
// the latched IR/DR as one-cycle per-channel action pulses with a ready handshake.
module nios2_debug_cmd_bridge #(
   parameter int IR_W = 2,
   parameter int DR_W = 38,
   parameter int NUM_CH = 4,
   parameter int ACT_BIT = 34,
   parameter int SYNC_STAGES = 2
) (
   input logic clk,
   input logic reset,
   nios2_debug_cmd_bridge_if.slave b
);
   localparam int NSEL = 2 ** IR_W;
   typedef enum logic [1:0] {IDLE, DISPATCH, WAIT} state_t;
   state_t state_q, state_d;
   logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d, uir_sync_q, uir_sync_d;
   logic udr_dly_q, udr_dly_d, uir_dly_q, uir_dly_d;
   logic [DR_W-1:0] jdo_q, jdo_d;
   logic [IR_W-1:0] ir_q, ir_d;
   logic overrun_q, overrun_d, invalid_q, invalid_d;
   logic [15:0] cmd_count_q, cmd_count_d;
   logic udr_rise, uir_rise, valid, rdy;
   logic [NSEL-1:0] rdy_ext;
   logic [NUM_CH-1:0] onehot;

   assign udr_rise = udr_sync_q[SYNC_STAGES-1] & ~udr_dly_q;
   assign uir_rise = uir_sync_q[SYNC_STAGES-1] & ~uir_dly_q;
   assign rdy_ext = NSEL'(b.ch_ready);
   assign valid = {1'b0, ir_q} < (IR_W+1)'(NUM_CH);
   assign rdy = rdy_ext[ir_q];

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         udr_sync_q <= '0;
         uir_sync_q <= '0;
         udr_dly_q <= 1'b0;
         uir_dly_q <= 1'b0;
         jdo_q <= '0;
         ir_q <= '0;
         overrun_q <= 1'b0;
         invalid_q <= 1'b0;
         cmd_count_q <= '0;
      end else begin
         state_q <= state_d;
         udr_sync_q <= udr_sync_d;
         uir_sync_q <= uir_sync_d;
         udr_dly_q <= udr_dly_d;
         uir_dly_q <= uir_dly_d;
         jdo_q <= jdo_d;
         ir_q <= ir_d;
         overrun_q <= overrun_d;
         invalid_q <= invalid_d;
         cmd_count_q <= cmd_count_d;
      end

   always_comb begin
      udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], b.vs_udr};
      uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], b.vs_uir};
      udr_dly_d = udr_sync_q[SYNC_STAGES-1];
      uir_dly_d = uir_sync_q[SYNC_STAGES-1];
      state_d = state_q;
      jdo_d = jdo_q;
      ir_d = ir_q;
      cmd_count_d = cmd_count_q;
      // set events take priority over err_clr
      overrun_d = (overrun_q & ~b.err_clr) | (udr_rise & (state_q != IDLE));
      invalid_d = (invalid_q & ~b.err_clr) | (state_q == DISPATCH && !valid);
      case (state_q)
         IDLE: if (udr_rise) begin
            jdo_d = b.sr;
            ir_d = b.ir_in;
            state_d = DISPATCH;
         end
         DISPATCH: begin
            cmd_count_d = valid ? cmd_count_q + 16'd1 : cmd_count_q;
            state_d = (!valid || rdy) ? IDLE : WAIT;
         end
         WAIT: state_d = (uir_rise || rdy) ? IDLE : WAIT;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      onehot = (state_q == DISPATCH && valid) ? NUM_CH'(1) << ir_q : '0;
      b.take_action = jdo_q[ACT_BIT] ? onehot : '0;
      b.take_no_action = jdo_q[ACT_BIT] ? '0 : onehot;
      b.busy = state_q != IDLE;
      b.jdo = jdo_q;
      b.ir_latched = ir_q;
      b.overrun = overrun_q;
      b.invalid_ir = invalid_q;
      b.cmd_count = cmd_count_q;
   end
endmodule

// File: tb/tb_nios2_debug_cmd_bridge.sv
// tb_nios2_debug_cmd_bridge: directed checks of dispatch, handshake, abort, overrun, invalid IR, wrap and reset.
module tb_nios2_debug_cmd_bridge;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   localparam logic [37:0] S1 = 38'h04_1234_5678;
   localparam logic [37:0] S2 = 38'h00_0000_ABCD;
   localparam logic [37:0] S3 = 38'h3F_0000_0001;
   localparam logic [37:0] S4 = 38'h01_2222_3333;
   localparam logic [37:0] S5 = 38'h00_5555_0000;
   localparam logic [37:0] S6 = 38'h24_0000_00FF;
   localparam logic [37:0] S7 = 38'h04_AAAA_BBBB;
   localparam logic [37:0] S8 = 38'h00_CCCC_DDDD;

   always #5 clk = ~clk;

   nios2_debug_cmd_bridge_if b ();
   nios2_debug_cmd_bridge_if #(.NUM_CH(3)) b3 ();
   nios2_debug_cmd_bridge dut (.clk(clk), .reset(reset), .b(b));
   nios2_debug_cmd_bridge #(.NUM_CH(3)) dut3 (.clk(clk), .reset(reset), .b(b3));

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input bit on3, input logic [1:0] ir, input logic [37:0] d);
      if (on3) begin
         b3.ir_in = ir; b3.sr = d; b3.vs_udr = 1'b1;
      end else begin
         b.ir_in = ir; b.sr = d; b.vs_udr = 1'b1;
      end
      tick();
      b.vs_udr = 1'b0;
      b3.vs_udr = 1'b0;
   endtask

   initial begin
      {b.vs_udr, b.vs_uir, b.err_clr, b.ir_in, b.sr, b.ch_ready} = '0;
      {b3.vs_udr, b3.vs_uir, b3.err_clr, b3.ir_in, b3.sr, b3.ch_ready} = '0;
      tick(); tick();
      chk("rst_busy", b.busy, 0);
      chk("rst_jdo", b.jdo, 0);
      chk("rst_cnt", b.cmd_count, 0);
      chk("rst_take", {b.take_action, b.take_no_action}, 0);
      reset = 1'b0;
      tick();
      // long strobe: single dispatch on the third edge
      b.ir_in = 2'd1; b.sr = S1; b.ch_ready = 4'b0010; b.vs_udr = 1'b1;
      tick(); chk("t1_e1_act", b.take_action, 0);
      tick(); chk("t1_e2_act", b.take_action, 0);
      tick();
      chk("t1_act", b.take_action, 4'b0010);
      chk("t1_noact", b.take_no_action, 0);
      chk("t1_jdo", b.jdo, S1);
      chk("t1_busy", b.busy, 1);
      tick();
      chk("t1_act_end", b.take_action, 0);
      chk("t1_busy_end", b.busy, 0);
      chk("t1_cnt", b.cmd_count, 1);
      tick();
      b.vs_udr = 1'b0;
      repeat (4) tick();
      chk("t1_single", b.cmd_count, 1);
      // no-action with delayed ready
      b.ch_ready = 4'b0000;
      send(0, 2'd2, S2); tick(); tick();
      chk("t2_noact", b.take_no_action, 4'b0100);
      chk("t2_act", b.take_action, 0);
      chk("t2_ir", b.ir_latched, 2);
      chk("t2_busy", b.busy, 1);
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("t2_wait_busy", b.busy, 1);
         chk("t2_wait_take", {b.take_action, b.take_no_action}, 0);
      end
      b.ch_ready = 4'b0100;
      tick();
      chk("t2_idle", b.busy, 0);
      chk("t2_cnt", b.cmd_count, 2);
      b.ch_ready = 4'b0000;
      // overrun during WAIT
      send(0, 2'd1, S3); tick(); tick();
      chk("t3_act", b.take_action, 4'b0010);
      tick();
      send(0, 2'd3, S4); tick(); tick();
      chk("t3_ovr", b.overrun, 1);
      chk("t3_jdo_held", b.jdo, S3);
      chk("t3_ir_held", b.ir_latched, 1);
      chk("t3_take", {b.take_action, b.take_no_action}, 0);
      chk("t3_busy", b.busy, 1);
      b.err_clr = 1'b1; tick(); b.err_clr = 1'b0;
      chk("t3_clr", b.overrun, 0);
      b.ch_ready = 4'b0010; tick();
      chk("t3_idle", b.busy, 0);
      chk("t3_cnt", b.cmd_count, 3);
      b.ch_ready = 4'b0000;
      // update-IR abort out of WAIT
      send(0, 2'd0, S5); tick(); tick();
      chk("t4_noact", b.take_no_action, 4'b0001);
      tick();
      b.vs_uir = 1'b1; tick(); b.vs_uir = 1'b0;
      tick(); tick();
      chk("t4_abort_busy", b.busy, 0);
      chk("t4_abort_take", {b.take_action, b.take_no_action}, 0);
      chk("t4_abort_cnt", b.cmd_count, 4);
      b.ch_ready = 4'b1000;
      send(0, 2'd3, S6); tick(); tick();
      chk("t4_next_act", b.take_action, 4'b1000);
      tick();
      chk("t4_next_idle", b.busy, 0);
      chk("t4_next_cnt", b.cmd_count, 5);
      b.ch_ready = 4'b0000;
      // simultaneous update-DR and update-IR in WAIT
      send(0, 2'd1, S7); tick(); tick();
      chk("t5_act", b.take_action, 4'b0010);
      tick();
      b.sr = S8; b.vs_udr = 1'b1; b.vs_uir = 1'b1;
      tick();
      b.vs_udr = 1'b0; b.vs_uir = 1'b0;
      tick(); tick();
      chk("t5_busy", b.busy, 0);
      chk("t5_ovr", b.overrun, 1);
      chk("t5_jdo", b.jdo, S7);
      tick();
      chk("t5_dropped", {b.busy, b.take_action, b.take_no_action}, 0);
      chk("t5_cnt", b.cmd_count, 6);
      b.err_clr = 1'b1; tick(); b.err_clr = 1'b0;
      // three-channel instance: IR 3 is invalid
      b3.ch_ready = 3'b111;
      send(1, 2'd3, S1); tick(); tick();
      chk("t6_take", {b3.take_action, b3.take_no_action}, 0);
      chk("t6_busy", b3.busy, 1);
      tick();
      chk("t6_inv", b3.invalid_ir, 1);
      chk("t6_idle", b3.busy, 0);
      chk("t6_cnt", b3.cmd_count, 0);
      send(1, 2'd2, S1); tick(); tick();
      chk("t6_valid_act", b3.take_action, 3'b100);
      tick();
      chk("t6_valid_cnt", b3.cmd_count, 1);
      chk("t6_inv_sticky", b3.invalid_ir, 1);
      b3.err_clr = 1'b1; tick(); b3.err_clr = 1'b0;
      chk("t6_inv_clr", b3.invalid_ir, 0);
      // counter wrap from 0xFFFF
      force dut.cmd_count_d = 16'hFFFF;
      tick();
      release dut.cmd_count_d;
      tick();
      chk("t7_preload", b.cmd_count, 16'hFFFF);
      b.ch_ready = 4'b1111;
      send(0, 2'd1, S1); tick(); tick();
      chk("t7_act", b.take_action, 4'b0010);
      tick();
      chk("t7_wrap", b.cmd_count, 0);
      b.ch_ready = 4'b0000;
      // asynchronous reset while waiting
      send(0, 2'd2, S2); tick(); tick(); tick();
      chk("t8_wait", b.busy, 1);
      #2 reset = 1'b1;
      #1;
      chk("t8_busy", b.busy, 0);
      chk("t8_jdo", b.jdo, 0);
      chk("t8_ir", b.ir_latched, 0);
      chk("t8_cnt", b.cmd_count, 0);
      chk("t8_flags", {b.overrun, b.invalid_ir, b.take_action, b.take_no_action}, 0);
      tick(); reset = 1'b0;
      tick(); tick(); tick();
      chk("t8_after", {b.busy, b.take_action, b.take_no_action}, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
